// File: rtl/ltssm_pkg.sv
// Shared LTSSM definitions: timer interval codes, PIPE constants and the Detect substate encoding.
package ltssm_pkg;

  localparam logic [2:0] T12MS = 3'b001;
  localparam logic [2:0] T2MS  = 3'b100;
  localparam logic [2:0] T0MS  = 3'b000;

  localparam logic [2:0] RXSTAT_RX_PRESENT = 3'b011;
  localparam logic [1:0] PD_P1             = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    QUIET,
    ACT_REQ,
    ACT_WAIT,
    RETRY_WAIT,
    ACT2_REQ,
    ACT2_WAIT,
    DONE
  } det_state_t;

  // States that own the shared timer and therefore restart it on entry.
  function automatic logic isTimed(input det_state_t s);
    return (s == QUIET) || (s == ACT_WAIT) || (s == RETRY_WAIT) || (s == ACT2_WAIT);
  endfunction

  function automatic logic [2:0] intervalCode(input det_state_t s);
    case (s)
      QUIET, RETRY_WAIT:   return T12MS;
      ACT_WAIT, ACT2_WAIT: return T2MS;
      default:             return T0MS;
    endcase
  endfunction

endpackage

// File: rtl/detect_mask_capture.sv
// Per-lane receiver-present decode, first-attempt mask capture and the all/none/match flags used
// by the Detect FSM. Also holds the DetectedLanes result register.
module detect_mask_capture
  import ltssm_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic               Pclk,
  input  logic               Reset,
  input  logic [3*LANES-1:0] RxStatus,
  input  logic               CaptureFirst,
  input  logic               LoadDetected,
  output logic               MaskAll,
  output logic               MaskNone,
  output logic               MaskMatch,
  output logic [LANES-1:0]   DetectedLanes
);

  logic [LANES-1:0] liveMask;
  logic [LANES-1:0] firstMask;

  always_comb begin
    liveMask = '0;
    for (int i = 0; i < LANES; i++) begin
      liveMask[i] = (RxStatus[3*i +: 3] == RXSTAT_RX_PRESENT);
    end
  end

  // The live mask is only meaningful in the PhyStatus cycle, so it is latched there for the retry compare.
  always_ff @(posedge Pclk) begin
    if (!Reset) begin
      firstMask     <= '0;
      DetectedLanes <= '0;
    end else begin
      if (CaptureFirst) begin
        firstMask <= liveMask;
      end
      if (LoadDetected) begin
        DetectedLanes <= liveMask;
      end
    end
  end

  assign MaskAll   = &liveMask;
  assign MaskNone  = ~|liveMask;
  assign MaskMatch = (liveMask == firstMask);

endmodule

// File: rtl/detect_substate_fsm.sv
// LTSSM Detect.Quiet / Detect.Active controller driving the PIPE receiver-detect handshake and the
// shared timer. Optional attempt counter enabled by defining DETECT_ATTEMPT_CNT_EN.
module detect_substate_fsm
  import ltssm_pkg::*;
#(
  parameter int LANES          = 4,
  parameter int DET_CODE_WIDTH = 3
) (
  input  logic                      Pclk,
  input  logic                      Reset,
  input  logic                      DetectEn,
  input  logic                      TimeOut,
  output logic                      TimerStart,
  output logic [DET_CODE_WIDTH-1:0] TimerIntervalCode,
  output logic                      TimerEnable,
  input  logic                      PhyStatus,
  input  logic [3*LANES-1:0]        RxStatus,
  input  logic [LANES-1:0]          RxElecIdle,
  output logic                      TxDetectRx,
  output logic [1:0]                PowerDown,
  output logic                      DetectDone,
  output logic [LANES-1:0]          DetectedLanes
`ifdef DETECT_ATTEMPT_CNT_EN
  ,
  output logic [7:0]                DetectAttempts,
  output logic                      DetectStuck
`endif
);

  det_state_t state;
  det_state_t stateNext;
  logic       timerStartQ;
  logic       idleLowQ;
  logic       idleLow;
  logic       timeoutQual;
  logic       captureFirst;
  logic       loadDetected;
  logic       maskAll;
  logic       maskNone;
  logic       maskMatch;

  assign idleLow     = ~&RxElecIdle;
  // The timer still shows the previous interval's TimeOut during the restart pulse.
  assign timeoutQual = TimeOut & ~timerStartQ;

  detect_mask_capture #(
    .LANES(LANES)
  ) u_mask (
    .Pclk         (Pclk),
    .Reset        (Reset),
    .RxStatus     (RxStatus),
    .CaptureFirst (captureFirst),
    .LoadDetected (loadDetected),
    .MaskAll      (maskAll),
    .MaskNone     (maskNone),
    .MaskMatch    (maskMatch),
    .DetectedLanes(DetectedLanes)
  );

  always_ff @(posedge Pclk) begin
    if (!Reset) begin
      state       <= IDLE;
      timerStartQ <= 1'b0;
      idleLowQ    <= 1'b0;
    end else begin
      state       <= stateNext;
      timerStartQ <= (stateNext != state) && isTimed(stateNext);
      idleLowQ    <= (state == QUIET) && idleLow;
    end
  end

  always_comb begin
    stateNext = state;
    if (!DetectEn) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE:       stateNext = QUIET;
        QUIET: begin
          if (timeoutQual || (idleLow && idleLowQ)) begin
            stateNext = ACT_REQ;
          end
        end
        ACT_REQ:    stateNext = ACT_WAIT;
        // PhyStatus is tested first so a same-cycle guard expiry loses to a real result.
        ACT_WAIT: begin
          if (PhyStatus) begin
            if (maskAll) begin
              stateNext = DONE;
            end else if (maskNone) begin
              stateNext = QUIET;
            end else begin
              stateNext = RETRY_WAIT;
            end
          end else if (timeoutQual) begin
            stateNext = QUIET;
          end
        end
        RETRY_WAIT: begin
          if (timeoutQual) begin
            stateNext = ACT2_REQ;
          end
        end
        ACT2_REQ:   stateNext = ACT2_WAIT;
        ACT2_WAIT: begin
          if (PhyStatus) begin
            stateNext = (maskMatch && !maskNone) ? DONE : QUIET;
          end else if (timeoutQual) begin
            stateNext = QUIET;
          end
        end
        DONE:       stateNext = IDLE;
        default:    stateNext = IDLE;
      endcase
    end
  end

  always_comb begin
    captureFirst      = (state == ACT_WAIT) && PhyStatus && DetectEn;
    loadDetected      = (stateNext == DONE);
    TimerStart        = timerStartQ;
    TimerIntervalCode = DET_CODE_WIDTH'(intervalCode(state));
    TimerEnable       = isTimed(state);
    TxDetectRx        = (state == ACT_REQ) || (state == ACT_WAIT) ||
                        (state == ACT2_REQ) || (state == ACT2_WAIT);
    PowerDown         = PD_P1;
    DetectDone        = (state == DONE) && DetectEn;
  end

`ifdef DETECT_ATTEMPT_CNT_EN
  logic [7:0] attemptCnt;

  // Restarted at each fresh Detect entry; saturates so a stuck link stays visible.
  always_ff @(posedge Pclk) begin
    if (!Reset) begin
      attemptCnt <= '0;
    end else if ((state == IDLE) && (stateNext == QUIET)) begin
      attemptCnt <= '0;
    end else if ((stateNext != state) && ((stateNext == ACT_REQ) || (stateNext == ACT2_REQ)) &&
                 (attemptCnt != 8'hFF)) begin
      attemptCnt <= attemptCnt + 8'd1;
    end
  end

  assign DetectAttempts = attemptCnt;
  assign DetectStuck    = (attemptCnt == 8'hFF);
`endif

endmodule

// File: tb/tb_detect_substate_fsm.sv
// Scoreboard bench for detect_substate_fsm: bench plays timer and PHY, a transaction-level model
// predicts timer restarts and detect results, and a negedge monitor checks them as the DUT presents them.
module tb_detect_substate_fsm;

  localparam int LANES     = 4;
  localparam int QUIET_LEN = 12;
  localparam int GUARD_LEN = 8;

  logic                 Pclk       = 1'b0;
  logic                 Reset      = 1'b0;
  logic                 DetectEn   = 1'b0;
  logic                 PhyStatus  = 1'b0;
  logic [3*LANES-1:0]   RxStatus   = '0;
  logic [LANES-1:0]     RxElecIdle = '1;
  logic                 TimeOut;
  logic                 TimerStart;
  logic [2:0]           TimerIntervalCode;
  logic                 TimerEnable;
  logic                 TxDetectRx;
  logic [1:0]           PowerDown;
  logic                 DetectDone;
  logic [LANES-1:0]     DetectedLanes;
`ifdef DETECT_ATTEMPT_CNT_EN
  logic [7:0]           DetectAttempts;
  logic                 DetectStuck;
`endif

  int checks   = 0;
  int failures = 0;

  logic [2:0]       codeQ[$];
  logic [LANES-1:0] doneQ[$];
  bit               secondPhase  = 1'b0;
  logic [LANES-1:0] m1Model      = '0;
  logic [LANES-1:0] lastLanes    = '0;
  int               attemptsModel = 0;

  logic timerHold  = 1'b0;
  int   timerCnt   = 0;
  bit   timerArmed = 1'b0;

  always #5 Pclk = ~Pclk;

  detect_substate_fsm #(
    .LANES(LANES),
    .DET_CODE_WIDTH(3)
  ) dut (
    .Pclk             (Pclk),
    .Reset            (Reset),
    .DetectEn         (DetectEn),
    .TimeOut          (TimeOut),
    .TimerStart       (TimerStart),
    .TimerIntervalCode(TimerIntervalCode),
    .TimerEnable      (TimerEnable),
    .PhyStatus        (PhyStatus),
    .RxStatus         (RxStatus),
    .RxElecIdle       (RxElecIdle),
    .TxDetectRx       (TxDetectRx),
    .PowerDown        (PowerDown),
    .DetectDone       (DetectDone),
    .DetectedLanes    (DetectedLanes)
`ifdef DETECT_ATTEMPT_CNT_EN
    ,
    .DetectAttempts   (DetectAttempts),
    .DetectStuck      (DetectStuck)
`endif
  );

  // Scaled-down behavioural timer: 001 -> QUIET_LEN cycles, 100 -> GUARD_LEN cycles.
  always @(posedge Pclk) begin
    if (TimerStart) begin
      timerArmed <= 1'b1;
      timerCnt   <= (TimerIntervalCode == 3'b001) ? QUIET_LEN :
                    (TimerIntervalCode == 3'b100) ? GUARD_LEN : 0;
    end else if (TimerEnable && timerCnt != 0) begin
      timerCnt <= timerCnt - 1;
    end
  end
  assign TimeOut = timerArmed && (timerCnt == 0) && !TimerStart && !timerHold;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportFail(input string name, input string detail);
    checks++;
    failures++;
    $display("[TB] FAIL %s %s at %0t", name, detail, $time);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_timer_start"}, TimerStart, 0);
    checkOutput({tag, "_timer_code"}, TimerIntervalCode, 0);
    checkOutput({tag, "_timer_enable"}, TimerEnable, 0);
    checkOutput({tag, "_txdetectrx"}, TxDetectRx, 0);
    checkOutput({tag, "_powerdown"}, PowerDown, 2'b10);
    checkOutput({tag, "_detect_done"}, DetectDone, 0);
    checkOutput({tag, "_detected_lanes"}, DetectedLanes, 0);
  endtask

  function automatic logic [3*LANES-1:0] encodeStatus(input logic [LANES-1:0] m);
    logic [3*LANES-1:0] s;
    logic [2:0]         junk;
    for (int i = 0; i < LANES; i++) begin
      junk = 3'($urandom_range(0, 7));
      if (junk == 3'b011) junk = 3'b111;
      s[3*i +: 3] = m[i] ? 3'b011 : junk;
    end
    return s;
  endfunction

  // Spec-level outcome of one receiver-detect result (responded=0 means the guard expired).
  task automatic predictOutcome(input bit responded, input logic [LANES-1:0] m);
    logic [LANES-1:0] full;
    bit               done;
    logic [LANES-1:0] lanes;
    full  = '1;
    done  = 1'b0;
    lanes = '0;
    if (!secondPhase) begin
      if (responded && m == full) begin
        done  = 1'b1;
        lanes = m;
      end else if (responded && m != 0) begin
        m1Model     = m;
        secondPhase = 1'b1;
      end
    end else begin
      secondPhase = 1'b0;
      if (responded && m == m1Model && m != 0) begin
        done  = 1'b1;
        lanes = m1Model;
      end
    end
    if (done) begin
      doneQ.push_back(lanes);
      lastLanes     = lanes;
      attemptsModel = 0;
    end
    codeQ.push_back(3'b001);
  endtask

  task automatic waitRequest(output bit ok);
    int waited;
    waited = 0;
    while (TxDetectRx !== 1'b1 && waited < 400) begin
      @(negedge Pclk);
      waited++;
    end
    ok = (TxDetectRx === 1'b1);
    if (!ok) begin
      reportFail("request_timeout", "TxDetectRx never rose within 400 cycles");
      return;
    end
    codeQ.push_back(3'b100);
    attemptsModel = (attemptsModel < 255) ? attemptsModel + 1 : 255;
`ifdef DETECT_ATTEMPT_CNT_EN
    checkOutput("detect_attempts", DetectAttempts, attemptsModel);
    checkOutput("detect_stuck", DetectStuck, (attemptsModel == 255) ? 1 : 0);
`endif
  endtask

  // kind 0: PHY answers with mask after delay cycles of ACT_WAIT; kind 1: PHY never answers.
  task automatic applyStimulus(input int kind, input logic [LANES-1:0] mask, input int delay);
    bit ok;
    int waited;
    waitRequest(ok);
    if (!ok) return;
    if (kind == 1) begin
      predictOutcome(1'b0, '0);
      waited = 0;
      do begin
        @(negedge Pclk);
        waited++;
      end while (TxDetectRx !== 1'b0 && waited < 40);
      checkOutput("guard_timeout_txdetect", TxDetectRx, 0);
      return;
    end
    repeat (1 + delay) @(posedge Pclk);
    #1;
    RxStatus  = encodeStatus(mask);
    PhyStatus = 1'b1;
    predictOutcome(1'b1, mask);
    @(posedge Pclk);
    #1;
    PhyStatus = 1'b0;
    RxStatus  = LANES == 0 ? '0 : (3*LANES)'({$urandom, $urandom});
    @(negedge Pclk);
    checkOutput("txdetect_drop", TxDetectRx, 0);
  endtask

  always @(negedge Pclk) begin
    if (TimerStart === 1'b1) begin
      if (codeQ.size() == 0) begin
        reportFail("unexpected_timer_start", $sformatf("code=%0h", TimerIntervalCode));
      end else begin
        checkOutput("timer_code", TimerIntervalCode, codeQ.pop_front());
      end
      checkOutput("timer_enable_on_start", TimerEnable, 1);
      if (TimerIntervalCode == 3'b001) checkOutput("txdetect_low_in_wait", TxDetectRx, 0);
    end
    if (DetectDone === 1'b1) begin
      if (doneQ.size() == 0) begin
        reportFail("unexpected_detect_done", $sformatf("lanes=%0h", DetectedLanes));
      end else begin
        checkOutput("detected_lanes", DetectedLanes, doneQ.pop_front());
      end
      checkOutput("txdetect_low_in_done", TxDetectRx, 0);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ok;

    repeat (3) @(posedge Pclk);
    @(negedge Pclk);
    checkResetValues("reset");
    @(posedge Pclk);
    #1 Reset = 1'b1;

    // Quiet with the timer frozen: stray PhyStatus and elec-idle deglitch.
    timerHold = 1'b1;
    codeQ.push_back(3'b001);
    DetectEn = 1'b1;
    repeat (4) @(negedge Pclk);
    @(posedge Pclk);
    #1;
    RxStatus  = encodeStatus('1);
    PhyStatus = 1'b1;
    @(posedge Pclk);
    #1 PhyStatus = 1'b0;
    repeat (3) @(negedge Pclk);
    checkOutput("phystatus_ignored", TxDetectRx, 0);
    @(posedge Pclk);
    #1 RxElecIdle = 4'hE;
    @(posedge Pclk);
    #1 RxElecIdle = '1;
    repeat (4) @(negedge Pclk);
    checkOutput("deglitch_one_cycle", TxDetectRx, 0);
    @(posedge Pclk);
    #1 RxElecIdle = 4'hE;
    @(posedge Pclk);
    @(posedge Pclk);
    #1;
    RxElecIdle = '1;
    timerHold  = 1'b0;
    @(negedge Pclk);
    checkOutput("deglitch_two_cycles", TxDetectRx, 1);
    applyStimulus(0, '1, 2);

    // Directed handshakes: retry match, retry mismatch, guard timeout, PhyStatus/TimeOut collision.
    applyStimulus(0, 4'b0011, 1);
    applyStimulus(0, 4'b0011, 3);
    applyStimulus(0, 4'b0011, 0);
    applyStimulus(0, 4'b0001, 4);
    applyStimulus(1, '0, 0);
    applyStimulus(0, '1, GUARD_LEN + 1);

    for (int n = 0; n < 40; n++) begin
      int               kind;
      int               delay;
      int               pick;
      logic [LANES-1:0] m;
      kind  = ($urandom_range(0, 9) == 0) ? 1 : 0;
      delay = $urandom_range(0, GUARD_LEN + 1);
      pick  = $urandom_range(0, 9);
      if (secondPhase && pick < 5) m = m1Model;
      else if (pick < 7)           m = LANES'($urandom);
      else if (pick < 9)           m = '1;
      else                         m = '0;
      applyStimulus(kind, m, delay);
    end

    // DetectEn withdrawn while waiting for PhyStatus.
    waitRequest(ok);
    @(posedge Pclk);
    #1 DetectEn = 1'b0;
    @(posedge Pclk);
    @(negedge Pclk);
    checkOutput("abort_txdetect", TxDetectRx, 0);
    checkOutput("abort_timer_enable", TimerEnable, 0);
    checkOutput("abort_lanes_retained", DetectedLanes, lastLanes);
    secondPhase = 1'b0;
    repeat (3) @(negedge Pclk);
    @(posedge Pclk);
    #1;
    codeQ.push_back(3'b001);
    attemptsModel = 0;
    DetectEn      = 1'b1;

    // Reset while in the retry wait.
    applyStimulus(0, 4'b0101, 2);
    repeat (3) @(negedge Pclk);
    @(posedge Pclk);
    #1 Reset = 1'b0;
    @(posedge Pclk);
    @(negedge Pclk);
    checkResetValues("midreset");
    secondPhase   = 1'b0;
    lastLanes     = '0;
    attemptsModel = 0;
    codeQ.push_back(3'b001);
    @(posedge Pclk);
    #1 Reset = 1'b1;
    applyStimulus(0, '1, 0);

`ifdef DETECT_ATTEMPT_CNT_EN
    // All lanes absent forever: the attempt counter must saturate.
    repeat (3) @(negedge Pclk);
    for (int n = 0; n < 260; n++) begin
      applyStimulus(0, '0, 0);
    end
    checkOutput("attempts_saturated", DetectAttempts, 255);
    checkOutput("stuck_flag", DetectStuck, 1);
`endif

    repeat (3) @(negedge Pclk);
    DetectEn = 1'b0;
    repeat (20) @(negedge Pclk);
    checkOutput("timer_expectations_drained", codeQ.size(), 0);
    checkOutput("done_expectations_drained", doneQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/detect_substate_fsm.md
Name: detect_substate_fsm

Overview:
- LTSSM Detect substate controller: runs Detect.Quiet and Detect.Active, drives the PIPE receiver-detect handshake and decides which lanes exit to Polling.
- Directly upstream of the shared LTSSM timer: drives the timer's Start and TimerIntervalCode, and consumes its TimeOut.
- Sits between the top-level LTSSM and the PIPE PHY interface.

Parameters:
- LANES, 4, number of PIPE lanes (1..16).
- DET_CODE_WIDTH, 3, width of the timer interval code.

Ports:
- Pclk  input  1  PIPE clock.
- Reset  input  1  synchronous, active-low.
- DetectEn  input  1  LTSSM grants Detect; level, held while in Detect.
- TimeOut  input  1  from timer; high once the interval has elapsed, forced low while TimerStart is high.
- TimerStart  output  1  one-cycle restart pulse to the timer.
- TimerIntervalCode  output  3  001=12ms, 100=2ms, 000=0ms.
- TimerEnable  output  1  timer count enable.
- PhyStatus  input  1  PIPE completion pulse, common to all lanes.
- RxStatus  input  3*LANES  per-lane PIPE status; 3'b011 means receiver present.
- RxElecIdle  input  LANES  per-lane electrical-idle indication.
- TxDetectRx  output  1  PIPE receiver-detect request.
- PowerDown  output  2  PIPE power state: P1=2'b10 throughout Detect.
- DetectDone  output  1  one-cycle pulse: exit to Polling.
- DetectedLanes  output  LANES  lanes that passed detect; valid with DetectDone and held until the next start.

Behaviour:
- Reset (Reset=0 at a Pclk edge): state=IDLE; all outputs low, except PowerDown=2'b10 and TimerIntervalCode=000. DetectedLanes=0.
- States: IDLE, QUIET, ACT_REQ, ACT_WAIT, RETRY_WAIT, ACT2_REQ, ACT2_WAIT, DONE.
- Timer rule:
  - On the cycle of entry into every timed state (QUIET, ACT_WAIT, RETRY_WAIT, ACT2_WAIT), TimerStart=1 for exactly one cycle.
  - The new TimerIntervalCode is presented in that same cycle and held stable for the whole state.
  - TimerEnable=1 in all timed states.
  - TimeOut is qualified only when TimerStart=0.
- IDLE → QUIET when DetectEn=1.
- QUIET (code 001, 12ms):
  - → ACT_REQ on qualified TimeOut, or when any RxElecIdle bit is 0 for 2 consecutive cycles (deglitch).
- ACT_REQ: TxDetectRx=1; next cycle → ACT_WAIT.
- ACT_WAIT (code 100, 2ms guard): TxDetectRx held 1.
  - On PhyStatus=1: capture mask M1[i] = (RxStatus[3i+2:3i]==3'b011); drop TxDetectRx the next cycle.
    - All ones → DONE with DetectedLanes=M1.
    - Zero → QUIET.
    - Otherwise → RETRY_WAIT.
  - Qualified TimeOut before PhyStatus: treat M1 as zero → QUIET.
- RETRY_WAIT (code 001, 12ms): → ACT2_REQ on qualified TimeOut.
- ACT2_REQ / ACT2_WAIT: same handshake as ACT_REQ / ACT_WAIT, capturing M2.
  - M2==M1 and nonzero → DONE with DetectedLanes=M1.
  - Otherwise, or on guard TimeOut → QUIET.
- DONE: DetectDone=1 for one cycle → IDLE.
- TxDetectRx never asserts outside ACT_REQ/ACT_WAIT/ACT2_REQ/ACT2_WAIT, and deasserts at most 1 cycle after PhyStatus.
- PhyStatus received in any state without a pending request is ignored.
- PhyStatus and TimeOut in the same cycle: PhyStatus wins.
- DetectEn=0 in any state: next cycle → IDLE; TxDetectRx=0; DetectedLanes retained; no DetectDone.
- Reset mid-handshake: immediate return to the reset values, no residual TxDetectRx.

Optional Feature:
- Macro: DETECT_ATTEMPT_CNT_EN.
- Enabled:
  - Adds output DetectAttempts[7:0]: counts entries into ACT_REQ and ACT2_REQ; saturates at 255.
  - Cleared on reset and on the IDLE→QUIET transition.
  - Adds output DetectStuck: 1 while DetectAttempts==255.
- Disabled: neither port exists; no counter logic.

Decomposition:
- Shared package ltssm_pkg:
  - Timer codes T12MS=3'b001, T2MS=3'b100, T0MS=3'b000.
  - PIPE constants RXSTAT_RX_PRESENT=3'b011, PD_P1=2'b10.
  - State enum det_state_t.
- One natural sub-module: detect_mask_capture. Per-lane RxStatus decode into the mask, capture on PhyStatus, and the all/none/equal comparison flags.
- The timer itself is instantiated by the parent, not here.

Test Plan:
1. LANES=4, reset released, DetectEn=1, RxElecIdle=4'hF, no activity → TimerStart pulse with code 001; after TimeOut, TxDetectRx=1; PhyStatus with RxStatus all 3'b011 → DetectDone pulse, DetectedLanes=4'hF.
2. In QUIET, RxElecIdle=4'hE for 2 cycles → ACT_REQ before TimeOut. The same stimulus for 1 cycle only → stays in QUIET.
3. First detect mask 4'b0011, second 4'b0011 after the 12ms wait → DetectDone, DetectedLanes=4'b0011. Second mask 4'b0001 instead → return to QUIET, no DetectDone.
4. No PhyStatus after TxDetectRx → 2ms guard TimeOut → TxDetectRx=0, QUIET with code 001 and a fresh TimerStart.
5. DetectEn dropped in ACT_WAIT → TxDetectRx=0 next cycle, state IDLE. Separately, Reset=0 in RETRY_WAIT → all outputs at reset values.
6. With DETECT_ATTEMPT_CNT_EN, all lanes absent forever → DetectAttempts increments once per Quiet/Active loop; saturates at 255 with DetectStuck=1.
